reg_arbiter: RTL and testbench
==============================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001: The block SHALL have parameter N, default 4, giving the number of requesters (2..8).
REQ-002: The block SHALL have parameter W, default 4, giving the shared register data width.
REQ-003: The block SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004: The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005: The block SHALL have port req  input  N  per-requester write request, level.
REQ-006: The block SHALL have port din  input  N*W  per-requester write data; requester k at bits [k*W+W-1 : k*W].
REQ-007: The block SHALL have port gnt  output  N  one-hot grant, all zero when no transaction is active.
REQ-008: The block SHALL have port ack  output  1  single-cycle pulse marking write completion.
REQ-009: The block SHALL have port owner  output  clog2(N)  index of the requester that last wrote the register.
REQ-010: The block SHALL have port busy  output  1  high while in WRITE or DONE.
REQ-011: The block SHALL have port dout  output  W  current shared register value.

Function
REQ-012: The block SHALL contain one W-bit shared register that is written only in state WRITE.
REQ-013: The FSM SHALL have exactly three states: IDLE, WRITE and DONE.
REQ-014: IDLE SHALL go to WRITE when req is nonzero at the clock edge, latching the selected index sel; otherwise IDLE SHALL stay in IDLE.
REQ-015: sel SHALL be the first asserted req bit searched round-robin upward from ptr, wrapping N-1 to 0.
REQ-016: WRITE SHALL assert gnt[sel]; at the edge leaving WRITE the register SHALL load din[sel], owner SHALL load sel, and ptr SHALL load (sel+1) mod N.
REQ-017: WRITE SHALL always go to DONE, and din[sel] SHALL be sampled even if req[sel] has dropped.
REQ-018: DONE SHALL keep gnt[sel] asserted, assert ack for exactly that one cycle, and always go to IDLE.
REQ-019: Latency SHALL be request seen in IDLE at edge t, gnt high in cycles t+1 and t+2, dout updated from cycle t+2, ack high in cycle t+2.
REQ-020: Peak throughput SHALL be one write per 3 cycles, with back-to-back grants separated by one IDLE cycle.
REQ-021: Requests arriving during WRITE or DONE SHALL be ignored until the next IDLE evaluation, and no request SHALL be lost while it is held.
REQ-022: gnt SHALL be one-hot or zero in every cycle and SHALL never change while busy is high.
REQ-023: With all req bits held high, grants SHALL rotate 0,1,...,N-1,0, so no requester waits more than N transactions.
REQ-024: If only requester k requests repeatedly, it SHALL be granted every transaction.
REQ-025: ptr wrap SHALL be modulo N, including for non-power-of-two N, and sel SHALL never exceed N-1.
REQ-026: Outputs gnt, ack, busy, owner and dout SHALL be driven from registered state plus state decode only, with no combinational path from req or din.

Reset
REQ-027: rst_n low SHALL asynchronously force state to IDLE, the register to 0, owner to 0, ptr to 0, and gnt, ack and busy to 0.
REQ-028: rst_n asserted during WRITE or DONE SHALL abort the transaction: no ack is issued and the register reads 0.
REQ-029: After rst_n deasserts, the first IDLE evaluation SHALL occur at the first rising clk edge with rst_n high.

Verification (N=4, W=4)
REQ-030: Scenario: reset, then req=0010 with din[1]=0xA held -> gnt=0010 for 2 cycles, ack pulse in the second, dout=0xA, owner=1.
REQ-031: Scenario: req=1111 held for 12 cycles -> grant order 0,1,2,3 with ack every 3rd cycle and dout following din[k] of each grantee.
REQ-032: Scenario: req=0100, dropped to 0000 in the WRITE cycle with din[2]=0x5 -> write completes, dout=0x5, ack pulses once.
REQ-033: Scenario: after grant to requester 3, req=1001 -> next grant is 0 (wrap), then 3.
REQ-034: Scenario: rst_n pulled low mid-WRITE -> gnt=0, busy=0, dout=0 immediately, no ack; next request is granted normally starting from ptr=0.
REQ-035: Scenario: req=0001 toggling every cycle -> gnt never multi-hot, gnt and owner stable while busy, no glitch on ack.

Source files
------------

// File: rtl/reg_arbiter.sv
// reg_arbiter: round-robin arbiter granting N requesters write access to one
// shared W-bit register through an IDLE -> WRITE -> DONE handshake.
`default_nettype none

module reg_arbiter #(
  parameter int N = 4,
  parameter int W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       din,
  output logic [N-1:0]         gnt,
  output logic                 ack,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy,
  output logic [W-1:0]         dout
);

  localparam int SW = $clog2(N);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] WRITE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state;
  logic [SW-1:0] sel;
  logic [SW-1:0] ptr;
  logic [SW-1:0] pick;
  logic [W-1:0]  din_arr [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign din_arr[g] = din[g*W +: W];
  end

  // Round-robin search upward from ptr; the wide sum is folded back into
  // 0..N-1 so non-power-of-two N never yields an out-of-range index.
  always_comb begin
    logic          found;
    logic [SW:0]   idx_wide;
    logic [SW-1:0] idx;
    found    = 1'b0;
    pick     = '0;
    idx_wide = '0;
    idx      = '0;
    for (int i = 0; i < N; i++) begin
      idx_wide = {1'b0, ptr} + (SW+1)'(i);
      if (idx_wide >= (SW+1)'(N)) begin
        idx_wide = idx_wide - (SW+1)'(N);
      end
      idx = idx_wide[SW-1:0];
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
      owner <= '0;
      dout  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            sel   <= pick;
            state <= WRITE;
          end
        end
        WRITE: begin
          dout  <= din_arr[sel];
          owner <= sel;
          ptr   <= (sel == SW'(N-1)) ? '0 : sel + 1'b1;
          state <= DONE;
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only; req/din never reach them directly.
  assign busy = (state != IDLE);
  assign ack  = (state == DONE);
  assign gnt  = busy ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;

endmodule

`default_nettype wire

// File: tb/tb_reg_arbiter.sv
// tb_reg_arbiter: scoreboard bench for reg_arbiter (N=4, W=4).
`default_nettype none

module tb_reg_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] din;
  logic [N-1:0]   gnt;
  logic           ack;
  logic [1:0]     owner;
  logic           busy;
  logic [W-1:0]   dout;

  typedef struct {
    int           idx;
    logic [W-1:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   mptr     = 0;

  reg_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .din   (din),
    .gnt   (gnt),
    .ack   (ack),
    .owner (owner),
    .busy  (busy),
    .dout  (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) begin
      if (r[(p + i) % N]) return (p + i) % N;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] din_of(input int k);
    return din[k*W +: W];
  endfunction

  // Queue the expected grantee for a request pattern about to be sampled.
  task automatic push_expect(input logic [N-1:0] r, output int k);
    exp_t e;
    k      = rr_pick(r, mptr);
    e.idx  = k;
    e.data = din_of(k);
    sb.push_back(e);
    mptr   = (k + 1) % N;
  endtask

  // One full 3-cycle transaction, optionally dropping req during WRITE.
  task automatic txn(input logic [N-1:0] r, input bit drop);
    int k;
    @(negedge clk);
    req = r;
    push_expect(r, k);
    @(posedge clk); #1;
    check("write_gnt",  gnt,  32'(1) << k);
    check("write_busy", busy, 1);
    check("write_ack",  ack,  0);
    if (drop) req = '0;
    @(posedge clk); #1;
    check("done_ack",   ack,   1);
    check("done_owner", owner, k);
    check("done_dout",  dout,  din_of(k));
    @(posedge clk);
  endtask

  // Monitor: invariants every cycle and scoreboard pop on each ack.
  initial begin
    logic [N-1:0] prev_gnt;
    logic         prev_busy;
    logic         prev_ack;
    exp_t         e;
    prev_gnt  = '0;
    prev_busy = 1'b0;
    prev_ack  = 1'b0;
    forever begin
      @(negedge clk);
      check("gnt_onehot0", $onehot0(gnt), 1);
      check("busy_vs_gnt", busy, (gnt != '0));
      if (busy && prev_busy) check("gnt_stable", gnt, prev_gnt);
      if (ack) begin
        check("ack_single", prev_ack, 0);
        if (sb.size() == 0) begin
          check("ack_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          check("sb_gnt",   gnt,   32'(1) << e.idx);
          check("sb_owner", owner, e.idx);
          check("sb_dout",  dout,  e.data);
        end
      end
      prev_gnt  = gnt;
      prev_busy = busy;
      prev_ack  = ack;
    end
  end

  initial begin
    int k;
    rst_n = 1'b0;
    req   = '0;
    din   = 16'h95A1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt",   gnt,   0);
    check("rst_ack",   ack,   0);
    check("rst_busy",  busy,  0);
    check("rst_dout",  dout,  0);
    check("rst_owner", owner, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single requester 1 with data 0xA.
    txn(4'b0010, 1'b0);
    check("s1_dout_hold", dout, 4'hA);

    // All requesters held: rotation continues from ptr=2, then wrap.
    din = 16'h6E2B;
    for (int i = 0; i < 4; i++) txn(4'b1111, 1'b0);

    // Request dropped in WRITE still completes with din[2].
    din = 16'h95A1;
    txn(4'b0100, 1'b1);
    check("drop_dout", dout, 4'h5);

    // Wrap: grant 3, then 1001 yields 0 then 3.
    txn(4'b1000, 1'b0);
    txn(4'b1001, 1'b0);
    txn(4'b1001, 1'b0);
    check("wrap_owner", owner, 3);

    // Reset mid-WRITE aborts; ptr returns to 0.
    txn(4'b0100, 1'b0);
    @(negedge clk);
    req = 4'b1000;
    @(posedge clk); #1;
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("abort_gnt",   gnt,   0);
    check("abort_busy",  busy,  0);
    check("abort_ack",   ack,   0);
    check("abort_dout",  dout,  0);
    check("abort_owner", owner, 0);
    req  = '0;
    mptr = 0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(4'b1111, 1'b0);
    check("post_rst_owner", owner, 0);

    // req[0] toggling every cycle: one grant per 4 cycles.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      req = (i % 2 == 0) ? 4'b0001 : 4'b0000;
      if (i % 4 == 0) push_expect(4'b0001, k);
    end
    @(negedge clk);
    req = '0;
    repeat (4) @(posedge clk);
    #1;
    check("sb_drained", sb.size(), 0);
    check("idle_end",   busy,      0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
